global_sequencer: RTL and testbench
===================================

Name: global_sequencer

Overview:
- Global control unit directly upstream of the cell grid.
- Fetches instructions from program memory and broadcasts each instruction to every core, together with the post-instruction program counter and stack pointer.
- Resolves grid-wide branches from the AND-reduced `diverge_consensus` returned by the grid.
- Maintains a return-address stack for CALL/RET and halts on HALT or on a stack fault.

Parameters:
- PC_W, 8, program-counter width; equals width of pc_t.
- SP_W, 4, stack-pointer width; equals width of sp_t.
- INSTR_W, 32, instruction width; equals width of instruction_t.
- STACK_DEPTH, 16, return-stack entries; must be at most 2**SP_W.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: one-cycle pulse; begins execution at PC 0 when idle or halted.
- imem_addr, output, PC_W: program memory read address.
- imem_rdata, input, INSTR_W: program memory data; valid 1 cycle after imem_addr.
- instruction, output, INSTR_W: broadcast instruction to grid.
- next_program_counter, output, PC_W: PC after the broadcast instruction.
- next_stack_pointer, output, SP_W: SP after the broadcast instruction.
- global_enable, output, 1: broadcast strobe; cores act only when high.
- diverge_consensus, input, 1: AND of all core diverge flags.
- busy, output, 1: high in every state except IDLE and HALT.
- halted, output, 1: high in HALT.
- fault, output, 1: sticky; set on stack overflow or underflow.

Behaviour:
- Reset values (asynchronous on rst high):
  - state=IDLE, pc=0, sp=0.
  - instruction=0, next_program_counter=0, next_stack_pointer=0.
  - global_enable=0, imem_addr=0, busy=0, halted=0, fault=0.
- Reset asserted mid-operation abandons the current instruction immediately; no partial broadcast follows.
- Decode fields: opcode=instruction[INSTR_W-1:INSTR_W-6]; target=instruction[PC_W-1:0].
  - 0x30 JMP
  - 0x31 BRC (branch if consensus)
  - 0x32 CALL
  - 0x33 RET
  - 0x3F HALT
  - All other opcodes are cell ops.
- State machine:
  - IDLE: waits for start. On start: pc=0, sp=0, fault=0; go to FETCH.
  - FETCH (1 cycle): imem_addr=pc; go to LATCH.
  - LATCH (1 cycle): capture imem_rdata into instr_q; compute next pc/sp; check stack fault; go to ISSUE, or to HALT on fault or HALT opcode.
  - ISSUE (1 cycle):
    - Outputs: instruction=instr_q, global_enable=1, next_program_counter and next_stack_pointer per the table below.
    - Non-BRC: commit pc/sp; go to FETCH.
    - BRC: go to WAIT.
  - WAIT (1 cycle): global_enable=0; cores register their diverge flags.
  - RESOLVE (1 cycle): sample diverge_consensus. 1 gives pc=target; 0 gives pc=pc+1. Go to FETCH.
  - HALT: halted=1; global_enable=0; outputs hold their last values. start re-enters FETCH with pc=0, sp=0, fault=0.
- Next PC/SP per opcode:
  - Cell op: pc+1; sp unchanged.
  - JMP: target; sp unchanged.
  - CALL: push pc+1 to stack[sp]; sp+1; next pc=target.
  - RET: sp-1; next pc=stack[sp-1].
  - BRC: next_program_counter broadcasts target; actual pc resolves in RESOLVE.
- Latency: 3 cycles per non-branch instruction, 5 per BRC. global_enable is high exactly 1 cycle per executed instruction.
- PC arithmetic is modulo 2**PC_W: pc+1 at the last address wraps to 0 with no fault.
- Stack faults are checked in LATCH:
  - CALL with sp==STACK_DEPTH: fault=1, go to HALT without broadcast.
  - RET with sp==0: fault=1, go to HALT without broadcast.
- HALT opcode is not broadcast (global_enable stays 0).
- start while busy is ignored.
- start and rst asserted together: rst wins.
- diverge_consensus is ignored outside RESOLVE.

Optional Feature:
- Macro: GLOBAL_SEQUENCER_STEP_EN.
- When defined:
  - Adds input step (1 bit) and input run_mode (1 bit).
  - With run_mode=0, the FSM stalls in FETCH until a step pulse, so exactly one instruction completes per step pulse.
  - A BRC completes through RESOLVE on its single step pulse.
  - With run_mode=1, behaviour matches the undefined case.
- When undefined: no step or run_mode ports; free-running execution.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: assert rst while global_enable=1.
  - Response: same cycle, global_enable=0, busy=0, pc=0; no further broadcast until start.
- Straight-line program:
  - Stimulus: mem[0..2]=cell ops 0x04000001, 0x04000002, 0x04000003; mem[3]=HALT; pulse start.
  - Response: global_enable pulses at cycles 3, 6, 9 after start, with next_program_counter 1, 2, 3. halted=1 after mem[3] is latched; HALT produces no fourth pulse.
- Branch taken vs not taken:
  - Stimulus: mem[0]=BRC target 0x10. Run 1 holds diverge_consensus=1 in RESOLVE; run 2 holds it at 0.
  - Response: next imem_addr is 0x10 in run 1 and 0x01 in run 2. The BRC occupies 5 cycles.
- CALL/RET:
  - Stimulus: mem[0]=CALL 0x20; mem[0x20]=RET.
  - Response: CALL broadcasts next_stack_pointer=1 and next_program_counter=0x20. RET broadcasts next_stack_pointer=0 and next_program_counter=1. Fetch resumes at 1.
- Stack faults:
  - Stimulus A: 17 nested CALLs with STACK_DEPTH=16. Response A: 17th CALL is not broadcast; fault=1, halted=1.
  - Stimulus B: RET at sp=0. Response B: fault=1, halted=1.
- PC wrap:
  - Stimulus: mem[0xFF] = cell op.
  - Response: next_program_counter=0x00; next fetch from 0x00; fault stays 0.

Source files
------------

// File: rtl/global_sequencer.sv
// Global sequencer: fetches from program memory, broadcasts each instruction to the grid,
// resolves grid-wide branches and keeps a CALL/RET stack. Optional GLOBAL_SEQUENCER_STEP_EN adds single-step.
module global_sequencer #(
  parameter int PC_W        = 8,
  parameter int SP_W        = 4,
  parameter int INSTR_W     = 32,
  parameter int STACK_DEPTH = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef GLOBAL_SEQUENCER_STEP_EN
  input  logic               step,
  input  logic               run_mode,
`endif
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    next_program_counter,
  output logic [SP_W-1:0]    next_stack_pointer,
  output logic               global_enable,
  input  logic               diverge_consensus,
  output logic               busy,
  output logic               halted,
  output logic               fault
);
  localparam logic [5:0] OP_JMP  = 6'h30;
  localparam logic [5:0] OP_BRC  = 6'h31;
  localparam logic [5:0] OP_CALL = 6'h32;
  localparam logic [5:0] OP_RET  = 6'h33;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [PC_W-1:0] PC_ONE  = 1;
  localparam logic [SP_W-1:0] SPI_ONE = 1;
  localparam logic [SP_W:0]   SP_ONE  = 1;
  // sp carries one extra bit so a completely full stack (sp==STACK_DEPTH) is representable
  localparam logic [SP_W:0]   SP_FULL = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_RESOLVE, S_HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, lat_pc, tgt;
  logic [SP_W:0]   sp, sp_nxt, lat_sp;
  logic [5:0]      op, op_q;
  logic [SP_W-1:0] ret_idx;
  logic            lat_fault, step_ok, push;
  logic [PC_W-1:0] stack [2**SP_W];

`ifdef GLOBAL_SEQUENCER_STEP_EN
  assign step_ok = run_mode | step;
`else
  assign step_ok = 1'b1;
`endif

  assign push = (state == S_ISSUE) && (op_q == OP_CALL);

  always_comb begin
    op        = imem_rdata[INSTR_W-1 -: 6];
    tgt       = imem_rdata[PC_W-1:0];
    pc_inc    = pc + PC_ONE;
    ret_idx   = sp[SP_W-1:0] - SPI_ONE;
    lat_pc    = pc_inc;
    lat_sp    = sp;
    lat_fault = 1'b0;
    case (op)
      OP_JMP, OP_BRC: lat_pc = tgt;
      OP_CALL: begin
        lat_pc    = tgt;
        lat_sp    = sp + SP_ONE;
        lat_fault = (sp == SP_FULL);
      end
      OP_RET: begin
        lat_pc    = stack[ret_idx];
        lat_sp    = sp - SP_ONE;
        lat_fault = (sp == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) stack[sp[SP_W-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      pc                   <= '0;
      sp                   <= '0;
      pc_nxt               <= '0;
      sp_nxt               <= '0;
      op_q                 <= '0;
      instruction          <= '0;
      next_program_counter <= '0;
      next_stack_pointer   <= '0;
      global_enable        <= 1'b0;
      imem_addr            <= '0;
      busy                 <= 1'b0;
      halted               <= 1'b0;
      fault                <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          pc        <= '0;
          sp        <= '0;
          fault     <= 1'b0;
          imem_addr <= '0;
          busy      <= 1'b1;
          halted    <= 1'b0;
          state     <= S_FETCH;
        end
        S_FETCH: if (step_ok) state <= S_LATCH;
        S_LATCH: begin
          op_q   <= op;
          pc_nxt <= lat_pc;
          sp_nxt <= lat_sp;
          if (lat_fault || op == OP_HALT) begin
            fault  <= fault | lat_fault;
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            instruction          <= imem_rdata;
            next_program_counter <= lat_pc;
            next_stack_pointer   <= lat_sp[SP_W-1:0];
            global_enable        <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          global_enable <= 1'b0;
          if (op_q == OP_BRC) state <= S_WAIT;
          else begin
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            imem_addr <= pc_nxt;
            state     <= S_FETCH;
          end
        end
        S_WAIT: state <= S_RESOLVE;
        S_RESOLVE: begin
          // pc_nxt holds the branch target; pc is still the BRC address
          pc        <= diverge_consensus ? pc_nxt : pc_inc;
          imem_addr <= diverge_consensus ? pc_nxt : pc_inc;
          state     <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_global_sequencer.sv
// Directed bench for global_sequencer: synchronous program memory model and hand-computed expectations.
module tb_global_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, diverge_consensus = 1'b0;
  logic [7:0]  imem_addr, next_program_counter;
  logic [31:0] imem_rdata = '0, instruction;
  logic [3:0]  next_stack_pointer;
  logic        global_enable, busy, halted, fault;
  logic [31:0] mem [256];
  int checks = 0, failures = 0, ge_cnt = 0, c0;

  global_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef GLOBAL_SEQUENCER_STEP_EN
    .step(1'b0), .run_mode(1'b1),
`endif
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
    .next_program_counter(next_program_counter), .next_stack_pointer(next_stack_pointer),
    .global_enable(global_enable), .diverge_consensus(diverge_consensus),
    .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= mem[imem_addr];
  always @(negedge clk) if (global_enable) ge_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; diverge_consensus = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_ge", {31'b0, global_enable}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_addr", {24'b0, imem_addr}, 0);
    chk("rst_npc", {24'b0, next_program_counter}, 0);
    chk("rst_instr", instruction, 0);

    // straight-line program; a start pulse mid-run must be ignored
    do_reset();
    mem[0] = 32'h04000001; mem[1] = 32'h04000002; mem[2] = 32'h04000003; mem[3] = 32'hFC000000;
    c0 = ge_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      chk("sl_fetch_ge", {31'b0, global_enable}, 0);
      chk("sl_busy", {31'b0, busy}, 1);
      chk("sl_addr", {24'b0, imem_addr}, i);
      start = (i == 1);
      tick(); start = 1'b0;
      chk("sl_latch_ge", {31'b0, global_enable}, 0);
      tick();
      chk("sl_issue_ge", {31'b0, global_enable}, 1);
      chk("sl_npc", {24'b0, next_program_counter}, i + 1);
      chk("sl_instr", instruction, 32'h04000001 + i);
      tick();
    end
    tick(2);
    chk("sl_halted", {31'b0, halted}, 1);
    chk("sl_busy_h", {31'b0, busy}, 0);
    chk("sl_hold_npc", {24'b0, next_program_counter}, 3);
    chk("sl_hold_instr", instruction, 32'h04000003);
    tick(4);
    chk("sl_pulses", ge_cnt - c0, 3);

    // branch taken (run 0) and not taken (run 1); consensus outside RESOLVE is opposite
    for (int r = 0; r < 2; r++) begin
      do_reset();
      mem[0] = 32'hC4000010;
      pulse_start();
      tick(2);
      chk("br_ge", {31'b0, global_enable}, 1);
      chk("br_npc", {24'b0, next_program_counter}, 8'h10);
      diverge_consensus = (r == 1);
      tick();
      chk("br_wait_ge", {31'b0, global_enable}, 0);
      tick();
      diverge_consensus = (r == 0);
      tick();
      diverge_consensus = (r == 1);
      chk("br_addr", {24'b0, imem_addr}, (r == 0) ? 8'h10 : 8'h01);
      tick();
      chk("br_gap_ge", {31'b0, global_enable}, 0);
      tick();
      chk("br_next_ge", {31'b0, global_enable}, 1);
      chk("br_next_npc", {24'b0, next_program_counter}, (r == 0) ? 8'h11 : 8'h02);
    end

    // CALL / RET
    do_reset();
    mem[0] = 32'hC8000020; mem[8'h20] = 32'hCC000000;
    pulse_start();
    tick(2);
    chk("call_ge", {31'b0, global_enable}, 1);
    chk("call_npc", {24'b0, next_program_counter}, 8'h20);
    chk("call_nsp", {28'b0, next_stack_pointer}, 1);
    tick();
    chk("call_addr", {24'b0, imem_addr}, 8'h20);
    tick(2);
    chk("ret_ge", {31'b0, global_enable}, 1);
    chk("ret_npc", {24'b0, next_program_counter}, 1);
    chk("ret_nsp", {28'b0, next_stack_pointer}, 0);
    tick();
    chk("ret_addr", {24'b0, imem_addr}, 1);

    // overflow: 17 nested CALLs, the last is not broadcast
    do_reset();
    for (int i = 0; i < 17; i++) mem[i] = 32'hC8000000 | (i + 1);
    c0 = ge_cnt;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick(2);
      chk("ovf_npc", {24'b0, next_program_counter}, i + 1);
      tick();
    end
    tick(2);
    chk("ovf_fault", {31'b0, fault}, 1);
    chk("ovf_halted", {31'b0, halted}, 1);
    chk("ovf_ge", {31'b0, global_enable}, 0);
    chk("ovf_pulses", ge_cnt - c0, 16);

    // underflow, then restart from HALT clears the fault
    do_reset();
    mem[0] = 32'hCC000000;
    c0 = ge_cnt;
    pulse_start();
    tick(2);
    chk("udf_fault", {31'b0, fault}, 1);
    chk("udf_halted", {31'b0, halted}, 1);
    chk("udf_busy", {31'b0, busy}, 0);
    chk("udf_pulses", ge_cnt - c0, 0);
    mem[0] = 32'h04000000;
    pulse_start();
    chk("restart_fault", {31'b0, fault}, 0);
    chk("restart_busy", {31'b0, busy}, 1);
    chk("restart_halted", {31'b0, halted}, 0);

    // PC wrap at 0xFF
    do_reset();
    mem[0] = 32'hC00000FF; mem[8'hFF] = 32'h04000005;
    pulse_start();
    tick(2);
    chk("wrap_jmp_npc", {24'b0, next_program_counter}, 8'hFF);
    tick(3);
    chk("wrap_ge", {31'b0, global_enable}, 1);
    chk("wrap_npc", {24'b0, next_program_counter}, 0);
    chk("wrap_instr", instruction, 32'h04000005);
    tick();
    chk("wrap_addr", {24'b0, imem_addr}, 0);
    chk("wrap_fault", {31'b0, fault}, 0);

    // reset mid-ISSUE clears immediately, no broadcast follows
    do_reset();
    mem[0] = 32'h04000001;
    pulse_start();
    tick(2);
    chk("mid_pre_ge", {31'b0, global_enable}, 1);
    rst = 1'b1;
    #1;
    chk("mid_ge", {31'b0, global_enable}, 0);
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_npc", {24'b0, next_program_counter}, 0);
    tick(); rst = 1'b0;
    c0 = ge_cnt;
    tick(8);
    chk("mid_pulses", ge_cnt - c0, 0);

    // start together with rst: rst wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick(3);
    chk("rst_start_busy", {31'b0, busy}, 0);
    chk("rst_start_ge", {31'b0, global_enable}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
